// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// write-buffer entry layout.
package dmem_pkg;

  localparam int unsigned WBUF_DEPTH_DEF = 4;
  localparam int unsigned WORD_AW        = 30;  // word address = byte address [31:2]

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [WORD_AW-1:0] addr;
    logic [31:0]        data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Circular write buffer: push/pop with occupancy flags, plus an associative
// lookup that returns the youngest entry whose word address matches.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wbuf_entry_t            pushEntry,
  input  logic                   pop,
  output wbuf_entry_t            headEntry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  logic [WORD_AW-1:0]     lookupAddr,
  output logic                   matchAny,
  output logic [31:0]            matchData
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wbuf_entry_t   entries [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic          doPush;
  logic          doPop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headEntry = entries[headPtr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + 1'b1;
      if (doPop)  headPtr <= headPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  // NOTE: payload storage is deliberately not reset; count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (doPush) entries[tailPtr] <= pushEntry;
  end

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    // NOTE: outputs get defaults first so no path through the loop infers a latch.
    matchAny  = 1'b0;
    matchData = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) < count && entries[PW'(headPtr + PW'(i))].addr == lookupAddr) begin
        matchAny  = 1'b1;
        matchData = entries[PW'(headPtr + PW'(i))].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: posted stores through a write buffer drained to a req/ack RAM.
// Build option DMEM_FWD_EN enables store-to-load forwarding from the write buffer.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF,
  parameter int unsigned RAM_AW     = 16   // at most 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memCe,
  input  logic              memWrite,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memwriteData,
  output logic [31:0]       memreadData,
  output logic              stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);

  dmem_state_t                 state;
  logic                        isLoad;
  logic                        isStore;
  logic                        push;
  logic                        pop;
  logic                        rdAck;
  logic                        needRead;
  logic                        fwdHit;
  logic [RAM_AW-1:0]           wordIdx;
  logic [RAM_AW-1:0]           drainAddr;
  logic [31:0]                 drainData;
  wbuf_entry_t                 pushEntry;
  wbuf_entry_t                 headEntry;
  logic [$clog2(WBUF_DEPTH):0] wbufCount;
  logic                        wbufFull;
  logic                        wbufEmpty;
  logic                        matchAny;
  logic [31:0]                 matchData;
  logic                        unusedBits;

  assign isLoad    = memCe && !memWrite;
  assign isStore   = memCe && memWrite;
  assign wordIdx   = memAddr[RAM_AW+1:2];
  assign pushEntry = '{addr: WORD_AW'(wordIdx), data: memwriteData};
  assign push      = isStore && !wbufFull;
  assign pop       = (state == WR) && ram_ack;
  assign rdAck     = (state == RD) && ram_ack;
  assign needRead  = isLoad && !matchAny;

  // An empty buffer drains the store being pushed this cycle instead of waiting a cycle.
  assign drainAddr = wbufEmpty ? wordIdx : headEntry.addr[RAM_AW-1:0];
  assign drainData = wbufEmpty ? memwriteData : headEntry.data;

  dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .count     (wbufCount),
    .full      (wbufFull),
    .empty     (wbufEmpty),
    .lookupAddr(WORD_AW'(wordIdx)),
    .matchAny  (matchAny),
    .matchData (matchData)
  );

`ifdef DMEM_FWD_EN
  assign fwdHit = isLoad && matchAny;

  always_comb begin
    memreadData = '0;
    if (fwdHit)               memreadData = matchData;
    else if (isLoad && rdAck) memreadData = ram_rdata;
  end

  assign unusedBits = ^{memAddr[31:RAM_AW+2], memAddr[1:0],
                        headEntry.addr[WORD_AW-1:RAM_AW], wbufCount};
`else
  // A matching load never hits; it stalls until the buffer drains, then reads RAM.
  assign fwdHit = 1'b0;

  always_comb begin
    memreadData = '0;
    if (isLoad && rdAck) memreadData = ram_rdata;
  end

  assign unusedBits = ^{memAddr[31:RAM_AW+2], memAddr[1:0],
                        headEntry.addr[WORD_AW-1:RAM_AW], wbufCount, matchData};
`endif

  always_comb begin
    stall = 1'b0;
    if (isStore)     stall = wbufFull;
    else if (isLoad) stall = !(fwdHit || rdAck);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (needRead) begin
            state    <= RD;
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= wordIdx;
          end else if (!wbufEmpty || push) begin
            state     <= WR;
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= drainAddr;
            ram_wdata <= drainData;
          end
        end
        WR, RD: begin
          if (ram_ack) begin
            state   <= IDLE;
            ram_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
